// File: rtl/rob_cdb_sink.sv
// rob_cdb_sink: reorder buffer on the receiving side of the common data bus.
// Dispatch allocates entries in program order at the tail, CDB broadcasts mark
// slots done out of order, and the head retires in order. A retiring taken
// branch flushes the whole buffer and presents a redirect PC.
//
// Handshakes: a transfer happens on a rising edge where both sides agree.
//   allocate : alloc_valid && alloc_ready  (alloc_valid while full is dropped)
//   retire   : commit_valid && commit_ready (commit_* hold stable while stalled)
//   capture  : cdb_valid alone; the buffer never back-pressures the CDB.
// commit_pc is an extra head-PC output for commit/trace logic.
module rob_cdb_sink #(
    parameter int ROB_DEPTH = 16,
    parameter int IDX_W     = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_rd,
    input  logic [31:0]      alloc_pc,
    input  logic             alloc_is_br,
    output logic             alloc_ready,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic             cdb_valid,
    input  logic [IDX_W-1:0] cdb_rob_idx,
    input  logic [31:0]      cdb_rd_v,
    input  logic             cdb_branch_taken,
    input  logic [31:0]      cdb_jump_pc,
    output logic             commit_valid,
    input  logic             commit_ready,
    output logic [IDX_W-1:0] commit_idx,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_rd_v,
    output logic             commit_flush,
    output logic [31:0]      commit_redirect_pc,
    output logic [31:0]      commit_pc,
    output logic             empty,
    output logic [IDX_W:0]   count
);

    localparam logic [IDX_W:0] PTR_ONE = (IDX_W+1)'(1);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [IDX_W:0] head_q, head_d;
    logic [IDX_W:0] tail_q, tail_d;

    logic        valid_q [ROB_DEPTH];
    logic        done_q  [ROB_DEPTH];
    logic [4:0]  rd_q    [ROB_DEPTH];
    logic [31:0] pc_q    [ROB_DEPTH];
    logic        is_br_q [ROB_DEPTH];
    logic [31:0] rd_v_q  [ROB_DEPTH];
    logic        taken_q [ROB_DEPTH];
    logic [31:0] jpc_q   [ROB_DEPTH];

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             full;
    logic             alloc_fire;
    logic             cdb_fire;
    logic             retire_fire;
    logic             flush_fire;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

    assign alloc_ready = ~full;
    assign alloc_idx   = tail_idx;
    assign count       = tail_q - head_q;
    assign empty       = (tail_q == head_q);

    // Head offer: everything except the index is zeroed unless the head is done.
    assign commit_valid       = valid_q[head_idx] & done_q[head_idx];
    assign commit_idx         = head_idx;
    assign commit_rd          = commit_valid ? rd_q[head_idx]   : 5'd0;
    assign commit_rd_v        = commit_valid ? rd_v_q[head_idx] : 32'd0;
    assign commit_pc          = commit_valid ? pc_q[head_idx]   : 32'd0;
    assign commit_flush       = commit_valid & is_br_q[head_idx] & taken_q[head_idx];
    assign commit_redirect_pc = commit_valid ? jpc_q[head_idx]  : 32'd0;

    // Capture only into allocated, not-yet-done slots; stale and duplicate
    // broadcasts are dropped so the first result wins.
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign cdb_fire    = cdb_valid & valid_q[cdb_rob_idx] & ~done_q[cdb_rob_idx];
    assign retire_fire = commit_valid & commit_ready;
    assign flush_fire  = retire_fire & commit_flush;

    // Pointer next-state: a retiring flush returns both pointers to zero.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (flush_fire) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (alloc_fire)  tail_d = tail_q + PTR_ONE;
            if (retire_fire) head_d = head_q + PTR_ONE;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage: allocate at tail, capture by CDB index, clear at head.
    // The three writes never collide: tail is unallocated unless full (no
    // allocate then), and a done head rejects captures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                done_q[i]  <= 1'b0;
                rd_q[i]    <= 5'd0;
                pc_q[i]    <= 32'd0;
                is_br_q[i] <= 1'b0;
                rd_v_q[i]  <= 32'd0;
                taken_q[i] <= 1'b0;
                jpc_q[i]   <= 32'd0;
            end
        end else if (flush_fire) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                done_q[i]  <= 1'b0;
                rd_q[i]    <= 5'd0;
                pc_q[i]    <= 32'd0;
                is_br_q[i] <= 1'b0;
                rd_v_q[i]  <= 32'd0;
                taken_q[i] <= 1'b0;
                jpc_q[i]   <= 32'd0;
            end
        end else begin
            if (alloc_fire) begin
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                rd_q[tail_idx]    <= alloc_rd;
                pc_q[tail_idx]    <= alloc_pc;
                is_br_q[tail_idx] <= alloc_is_br;
            end
            if (cdb_fire) begin
                done_q[cdb_rob_idx]  <= 1'b1;
                rd_v_q[cdb_rob_idx]  <= cdb_rd_v;
                taken_q[cdb_rob_idx] <= cdb_branch_taken;
                jpc_q[cdb_rob_idx]   <= cdb_jump_pc;
            end
            if (retire_fire) begin
                valid_q[head_idx] <= 1'b0;
                done_q[head_idx]  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rob_cdb_sink.sv
// Testbench for rob_cdb_sink: directed vectors, retirements checked against an
// expected-commit queue by a negedge monitor, plus direct status checks.
module tb_rob_cdb_sink;

    localparam int DEPTH = 16;
    localparam int IW    = 4;
    localparam int W     = IW + 5 + 32 + 1 + 32;

    logic          clk;
    logic          rst_n;
    logic          alloc_valid;
    logic [4:0]    alloc_rd;
    logic [31:0]   alloc_pc;
    logic          alloc_is_br;
    logic          alloc_ready;
    logic [IW-1:0] alloc_idx;
    logic          cdb_valid;
    logic [IW-1:0] cdb_rob_idx;
    logic [31:0]   cdb_rd_v;
    logic          cdb_branch_taken;
    logic [31:0]   cdb_jump_pc;
    logic          commit_valid;
    logic          commit_ready;
    logic [IW-1:0] commit_idx;
    logic [4:0]    commit_rd;
    logic [31:0]   commit_rd_v;
    logic          commit_flush;
    logic [31:0]   commit_redirect_pc;
    logic [31:0]   commit_pc;
    logic          empty;
    logic [IW:0]   count;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    rob_cdb_sink #(.ROB_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
        .alloc_is_br(alloc_is_br), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_rd_v(cdb_rd_v),
        .cdb_branch_taken(cdb_branch_taken), .cdb_jump_pc(cdb_jump_pc),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_idx(commit_idx), .commit_rd(commit_rd), .commit_rd_v(commit_rd_v),
        .commit_flush(commit_flush), .commit_redirect_pc(commit_redirect_pc),
        .commit_pc(commit_pc), .empty(empty), .count(count)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] mk(input logic [IW-1:0] idx, input logic [4:0] rd,
                                        input logic [31:0] v, input logic fl,
                                        input logic [31:0] rpc);
        return {idx, rd, v, fl, rpc};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every retirement handshake is compared with the queue head.
    always @(negedge clk) begin
        if (rst_n && commit_valid && commit_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected: got idx=%0d rd=%0d rd_v=%h, none expected",
                         commit_idx, commit_rd, commit_rd_v);
            end else begin
                logic [W-1:0] e;
                logic [W-1:0] a;
                e = exp_q.pop_front();
                a = mk(commit_idx, commit_rd, commit_rd_v, commit_flush, commit_redirect_pc);
                if (a !== e) begin
                    errors++;
                    $display("FAIL commit_data: got %h expected %h", a, e);
                end
            end
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_alloc(input logic [4:0] rd, input logic [31:0] pc, input logic br);
        alloc_valid = 1'b1;
        alloc_rd    = rd;
        alloc_pc    = pc;
        alloc_is_br = br;
        cyc();
        alloc_valid = 1'b0;
    endtask

    task automatic do_cdb(input logic [IW-1:0] idx, input logic [31:0] v,
                          input logic tk, input logic [31:0] jpc);
        cdb_valid        = 1'b1;
        cdb_rob_idx      = idx;
        cdb_rd_v         = v;
        cdb_branch_taken = tk;
        cdb_jump_pc      = jpc;
        cyc();
        cdb_valid = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        alloc_valid = 1'b0; alloc_rd = '0; alloc_pc = '0; alloc_is_br = 1'b0;
        cdb_valid = 1'b0; cdb_rob_idx = '0; cdb_rd_v = '0;
        cdb_branch_taken = 1'b0; cdb_jump_pc = '0;
        commit_ready = 1'b0;
        #3;
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_alloc_idx", alloc_idx, 0);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        cyc();
        rst_n = 1'b1;

        // In-order retire of out-of-order results.
        commit_ready = 1'b1;
        do_alloc(5'd1, 32'h10, 1'b0);
        do_alloc(5'd2, 32'h14, 1'b0);
        do_alloc(5'd3, 32'h18, 1'b0);
        check("t1_count", count, 3);
        check("t1_alloc_idx", alloc_idx, 3);
        exp_q.push_back(mk(0, 1, 32'h11, 0, 0));
        exp_q.push_back(mk(1, 2, 32'h22, 0, 0));
        exp_q.push_back(mk(2, 3, 32'h33, 0, 0));
        do_cdb(2, 32'h33, 0, 0);
        check("t1_no_commit_yet", commit_valid, 0);
        do_cdb(0, 32'h11, 0, 0);
        check("t1_first_commit", commit_valid, 1);
        check("t1_first_idx", commit_idx, 0);
        do_cdb(1, 32'h22, 0, 0);
        idle(3);
        check("t1_empty", empty, 1);
        check("t1_drained", exp_q.size(), 0);

        // Full and wrap.
        reset_dut();
        commit_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("t2_alloc_idx", alloc_idx, i);
            do_alloc(5'(i + 1), 32'h1000 + 32'(4 * i), 1'b0);
        end
        check("t2_count_full", count, 16);
        check("t2_ready_full", alloc_ready, 0);
        do_alloc(5'd31, 32'hdead, 1'b0);
        check("t2_extra_ignored", count, 16);
        check("t2_idx_wrapped", alloc_idx, 0);
        exp_q.push_back(mk(0, 1, 32'h500, 0, 0));
        do_cdb(0, 32'h500, 0, 0);
        check("t2_head_valid", commit_valid, 1);
        check("t2_ready_still_0", alloc_ready, 0);
        do_alloc(5'd20, 32'h2000, 1'b0);
        check("t2_count_after_retire", count, 15);
        check("t2_ready_after_retire", alloc_ready, 1);
        check("t2_idx_slot0", alloc_idx, 0);
        do_alloc(5'd20, 32'h2000, 1'b0);
        check("t2_count_refull", count, 16);
        check("t2_idx_after_wrap", alloc_idx, 1);
        check("t2_drained", exp_q.size(), 0);

        // Flush on a retiring taken branch.
        reset_dut();
        commit_ready = 1'b0;
        do_alloc(5'd1, 32'h100, 1'b1);
        do_alloc(5'd4, 32'h104, 1'b0);
        do_alloc(5'd5, 32'h108, 1'b0);
        do_cdb(0, 32'h104, 1, 32'h200);
        check("t3_flush", commit_flush, 1);
        check("t3_redirect", commit_redirect_pc, 32'h200);
        check("t3_pc", commit_pc, 32'h100);
        exp_q.push_back(mk(0, 1, 32'h104, 1, 32'h200));
        commit_ready = 1'b1;
        cdb_valid = 1'b1; cdb_rob_idx = 1; cdb_rd_v = 32'h77;
        cdb_branch_taken = 1'b0; cdb_jump_pc = 0;
        alloc_valid = 1'b1; alloc_rd = 5'd9; alloc_pc = 32'h10c; alloc_is_br = 1'b0;
        cyc();
        cdb_valid = 1'b0; alloc_valid = 1'b0;
        check("t3_empty", empty, 1);
        check("t3_count", count, 0);
        check("t3_alloc_idx", alloc_idx, 0);
        check("t3_no_commit", commit_valid, 0);
        do_cdb(1, 32'h11, 0, 0);
        do_cdb(2, 32'h22, 0, 0);
        check("t3_late_cdb_count", count, 0);
        check("t3_late_cdb_commit", commit_valid, 0);
        do_alloc(5'd6, 32'h200, 1'b0);
        check("t3_fresh_not_done", commit_valid, 0);
        check("t3_drained", exp_q.size(), 0);

        // Stale, duplicate, capture to tail, back-pressure.
        reset_dut();
        commit_ready = 1'b0;
        do_cdb(5, 32'h55, 0, 0);
        check("t4_stale_count", count, 0);
        check("t4_stale_commit", commit_valid, 0);
        do_alloc(5'd7, 32'h300, 1'b0);
        do_cdb(1, 32'h99, 0, 0);
        do_alloc(5'd8, 32'h304, 1'b0);
        do_cdb(0, 32'hAA, 0, 0);
        do_cdb(0, 32'hBB, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("t4_stall_valid", commit_valid, 1);
            check("t4_stall_idx", commit_idx, 0);
            check("t4_stall_rd_v", commit_rd_v, 32'hAA);
            check("t4_stall_count", count, 2);
            cyc();
        end
        exp_q.push_back(mk(0, 7, 32'hAA, 0, 0));
        commit_ready = 1'b1;
        cyc();
        commit_ready = 1'b0;
        check("t4_head_moved", commit_idx, 1);
        check("t4_count_1", count, 1);
        check("t4_tail_capture_ignored", commit_valid, 0);
        exp_q.push_back(mk(1, 8, 32'h88, 0, 0));
        commit_ready = 1'b1;
        do_cdb(1, 32'h88, 0, 0);
        idle(2);
        check("t4_empty", empty, 1);
        check("t4_drained", exp_q.size(), 0);

        // Asynchronous reset mid-operation.
        reset_dut();
        commit_ready = 1'b0;
        for (int i = 0; i < 5; i++) do_alloc(5'(i + 10), 32'h400 + 32'(4 * i), 1'b0);
        do_cdb(0, 32'hCC, 0, 0);
        check("t5_count5", count, 5);
        check("t5_head_done", commit_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_count", count, 0);
        check("t5_rst_empty", empty, 1);
        check("t5_rst_ready", alloc_ready, 1);
        check("t5_rst_idx", alloc_idx, 0);
        check("t5_rst_commit_valid", commit_valid, 0);
        check("t5_rst_commit_rd", commit_rd, 0);
        check("t5_rst_commit_rd_v", commit_rd_v, 0);
        cyc();
        rst_n = 1'b1;
        idle(2);
        check("final_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
